// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch predictor: 2-bit saturating counter
// encodings, BTB entry field widths and index/tag width helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam int VALID_W = 1;
    localparam int CTR_W   = 2;

    // PCs are word aligned, so bits [1:0] never take part in index or tag.
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int tag_w(input int pc_w, input int depth);
        return pc_w - $clog2(depth) - 2;
    endfunction

    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btb_table.sv
// -----------------------------------------------------------------------------
// btb_table
// Direct-mapped branch target buffer with a 2-bit counter per entry.
// Read side is purely combinational from the registered entries, so a read
// and a write to the same index in one cycle returns the old contents.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_rd_idx, i_rd_tag    lookup index/tag
//   o_rd_taken            lookup hit with counter in a taken state
//   o_rd_target           stored target of the looked-up entry
//   i_wr_en               resolve a control instruction this cycle
//   i_wr_idx, i_wr_tag    index/tag of the resolving instruction
//   i_wr_taken            actual direction
//   i_wr_target           actual target
// -----------------------------------------------------------------------------
module btb_table
    import branch_pkg::*;
#(
    parameter int PC_WIDTH  = 20,
    parameter int BTB_DEPTH = 16,
    localparam int IDX_W    = idx_w(BTB_DEPTH),
    localparam int TAG_W    = tag_w(PC_WIDTH, BTB_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_W-1:0]    i_rd_idx,
    input  logic [TAG_W-1:0]    i_rd_tag,
    output logic                o_rd_taken,
    output logic [PC_WIDTH-1:0] o_rd_target,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic [TAG_W-1:0]    i_wr_tag,
    input  logic                i_wr_taken,
    input  logic [PC_WIDTH-1:0] i_wr_target
);

    logic                r_valid  [BTB_DEPTH];
    logic [TAG_W-1:0]    r_tag    [BTB_DEPTH];
    logic [PC_WIDTH-1:0] r_target [BTB_DEPTH];
    ctr_t                r_ctr    [BTB_DEPTH];

    logic w_rd_hit;
    logic w_wr_hit;
    ctr_t w_rd_ctr;

    assign w_rd_ctr    = r_ctr[i_rd_idx];
    assign w_rd_hit    = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_taken  = w_rd_hit && w_rd_ctr[1];
    assign o_rd_target = r_target[i_rd_idx];

    assign w_wr_hit = r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= WNT;
            end
        end else if (i_wr_en) begin
            if (w_wr_hit) begin
                r_ctr[i_wr_idx] <= ctr_next(r_ctr[i_wr_idx], i_wr_taken);
                if (i_wr_taken) begin
                    r_target[i_wr_idx] <= i_wr_target;
                end
            end else if (i_wr_taken) begin
                r_valid[i_wr_idx]  <= 1'b1;
                r_tag[i_wr_idx]    <= i_wr_tag;
                r_target[i_wr_idx] <= i_wr_target;
                r_ctr[i_wr_idx]    <= WT;
            end
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
// Fetch-stage BTB lookup plus EX-stage branch/jump resolution. A mispredict
// in EX raises a one-cycle redirect (select_new_pc_out/flush_out) on the
// following clock. While that redirect is out, the EX instruction is on the
// wrong path and is neither resolved nor allowed to touch the table.
// Optional build macro: BRANCH_PERF_CNT_EN adds 32-bit wrapping counters of
// control instructions and mispredicts.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   fetch_pc_in                 fetch PC to look up
//   predict_taken_out/pc_out    prediction for fetch_pc_in
//   ex_valid_in, jmp_inst_in, jmp_use_r_in, branch_inst_in,
//   branch_use_r_in, branch_result_in       EX decode/compare flags
//   ex_pc_in, reg_a_data_in, reg_b_data_in, pc_offset_in   EX operands
//   ex_pred_taken_in, ex_pred_pc_in         prediction carried down the pipe
//   select_new_pc_out, pc_out, flush_out    redirect
//   branch_count_out, mispredict_count_out  (BRANCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int PC_WIDTH        = 20,
    parameter int PC_OFFSET_WIDTH = 26,
    parameter int BTB_DEPTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PC_WIDTH-1:0]        fetch_pc_in,
    output logic                       predict_taken_out,
    output logic [PC_WIDTH-1:0]        predict_pc_out,
    input  logic                       ex_valid_in,
    input  logic                       jmp_inst_in,
    input  logic                       jmp_use_r_in,
    input  logic                       branch_inst_in,
    input  logic                       branch_use_r_in,
    input  logic                       branch_result_in,
    input  logic [PC_WIDTH-1:0]        ex_pc_in,
    input  logic [DATA_WIDTH-1:0]      reg_a_data_in,
    input  logic [DATA_WIDTH-1:0]      reg_b_data_in,
    input  logic [PC_OFFSET_WIDTH-1:0] pc_offset_in,
    input  logic                       ex_pred_taken_in,
    input  logic [PC_WIDTH-1:0]        ex_pred_pc_in,
    output logic                       select_new_pc_out,
    output logic [PC_WIDTH-1:0]        pc_out,
    output logic                       flush_out
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]                branch_count_out,
    output logic [31:0]                mispredict_count_out
`endif
);

    localparam int IDX_W = idx_w(BTB_DEPTH);
    localparam int TAG_W = tag_w(PC_WIDTH, BTB_DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(4);

    logic                r_select;
    logic [PC_WIDTH-1:0] r_pc;

    logic                w_rd_taken;
    logic [PC_WIDTH-1:0] w_rd_target;
    logic [PC_WIDTH-1:0] w_reg_a_pc;
    logic [PC_WIDTH-1:0] w_jmp_target;
    logic [PC_WIDTH-1:0] w_br_target;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_seq_pc;
    logic                w_ctrl;
    logic                w_actual_taken;
    logic                w_mispredict;

    // ---------------- lookup ----------------
    btb_table #(
        .PC_WIDTH  (PC_WIDTH),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_idx    (fetch_pc_in[IDX_W+1:2]),
        .i_rd_tag    (fetch_pc_in[PC_WIDTH-1:IDX_W+2]),
        .o_rd_taken  (w_rd_taken),
        .o_rd_target (w_rd_target),
        .i_wr_en     (w_ctrl),
        .i_wr_idx    (ex_pc_in[IDX_W+1:2]),
        .i_wr_tag    (ex_pc_in[PC_WIDTH-1:IDX_W+2]),
        .i_wr_taken  (w_actual_taken),
        .i_wr_target (w_target)
    );

    assign predict_taken_out = w_rd_taken;
    assign predict_pc_out    = w_rd_taken ? w_rd_target : fetch_pc_in + PC_INC;

    // ---------------- resolution ----------------
    assign w_reg_a_pc   = PC_WIDTH'(reg_a_data_in);
    assign w_jmp_target = jmp_use_r_in ? w_reg_a_pc : PC_WIDTH'({pc_offset_in, 2'b00});
    assign w_br_target  = branch_use_r_in ? w_reg_a_pc
                        : ex_pc_in + PC_WIDTH'(reg_b_data_in << 2) + PC_INC;
    // A jump always wins if decode ever flags both.
    assign w_target     = jmp_inst_in ? w_jmp_target : w_br_target;
    assign w_seq_pc     = ex_pc_in + PC_INC;

    // The instruction in EX during a redirect cycle is on the wrong path.
    assign w_ctrl         = ex_valid_in && (jmp_inst_in || branch_inst_in) && !r_select;
    assign w_actual_taken = jmp_inst_in || (branch_inst_in && branch_result_in);
    assign w_mispredict   = w_ctrl &&
                            ((w_actual_taken != ex_pred_taken_in) ||
                             (w_actual_taken && (w_target != ex_pred_pc_in)));

    // ---------------- redirect register ----------------
    // r_select can never stay high two cycles: a redirect masks w_ctrl.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_select <= 1'b0;
            r_pc     <= '0;
        end else begin
            r_select <= w_mispredict;
            if (w_mispredict) begin
                r_pc <= w_actual_taken ? w_target : w_seq_pc;
            end
        end
    end

    assign select_new_pc_out = r_select;
    assign flush_out         = r_select;
    assign pc_out            = r_pc;

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_ctrl) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mispredict) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign branch_count_out     = r_branch_cnt;
    assign mispredict_count_out = r_mispredict_cnt;
`endif

endmodule
